// File: rtl/instr_fetch.sv
// instr_fetch: fetches the word at the current IP over a req/ack port, hands it to decode,
// and returns the IP adjustment as a one-cycle strobe. Optional feature macro: FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int WORD_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   update_clk,
    input  logic                   reset_clk,
    input  logic [WORD_WIDTH-1:0]  ip,
    output logic [WORD_WIDTH-1:0]  mem_addr,
    output logic                   mem_req,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   branch_taken,
    input  logic [WORD_WIDTH-1:0]  branch_offset,
    output logic [WORD_WIDTH-1:0]  adj,
    output logic                   adj_strobe,
    output logic                   fault
);
    typedef enum logic [2:0] {START, REQ, HOLD, ADV, SETTLE, FAULT} state_t;

    state_t                 state, state_nxt;
    logic [WORD_WIDTH-1:0]  mem_addr_nxt, adj_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    logic                   mem_req_nxt, instr_valid_nxt, adj_strobe_nxt, fault_nxt;

    // Two's-complement adjustment; the IP owns the modulo wrap of ip + adj.
    function automatic logic signed [WORD_WIDTH-1:0] sel_adj(
        input logic                  taken,
        input logic [WORD_WIDTH-1:0] offset
    );
        logic signed [WORD_WIDTH-1:0] r;
        r = taken ? $signed(offset) : $signed(WORD_WIDTH'(1));
        return r;
    endfunction

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             timeout;

    // The ack on the last allowed cycle still wins: timeout only fires when cycle
    // TIMEOUT_CYCLES itself ends without an ack.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) wait_cnt <= '0;
        else           wait_cnt <= wait_cnt_nxt;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) begin
            state       <= START;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            adj         <= '0;
            adj_strobe  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_req     <= mem_req_nxt;
            instr       <= instr_nxt;
            instr_valid <= instr_valid_nxt;
            adj         <= adj_nxt;
            adj_strobe  <= adj_strobe_nxt;
            fault       <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        mem_addr_nxt    = mem_addr;
        mem_req_nxt     = mem_req;
        instr_nxt       = instr;
        instr_valid_nxt = instr_valid;
        adj_nxt         = adj;
        adj_strobe_nxt  = 1'b0;
        fault_nxt       = fault;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_nxt    = wait_cnt;
`endif
        case (state)
            START: begin
                mem_addr_nxt = ip;
                mem_req_nxt  = 1'b1;
                state_nxt    = REQ;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_nxt = '0;
`endif
            end
            REQ: begin
                if (mem_ack) begin
                    instr_nxt       = mem_data;
                    instr_valid_nxt = 1'b1;
                    mem_req_nxt     = 1'b0;
                    state_nxt       = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout) begin
                    mem_req_nxt = 1'b0;
                    fault_nxt   = 1'b1;
                    state_nxt   = FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
`endif
            end
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    instr_valid_nxt = 1'b0;
                    adj_nxt         = sel_adj(branch_taken, branch_offset);
                    adj_strobe_nxt  = 1'b1;
                    state_nxt       = ADV;
                end
            end
            ADV: state_nxt = SETTLE;
            SETTLE: begin
                // ip already reflects the strobe from ADV.
                mem_addr_nxt = ip;
                mem_req_nxt  = 1'b1;
                state_nxt    = REQ;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_nxt = '0;
`endif
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = START;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of single-fetch vectors plus hand-written
// stall, asynchronous-reset, back-to-back and (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_instr_fetch;
    logic        update_clk = 1'b0;
    logic        reset_clk;
    logic [15:0] ip;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [15:0] adj;
    logic        adj_strobe;
    logic        fault;

    logic        ip_load;
    logic [15:0] ip_load_val;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch #(.WORD_WIDTH(16), .INSTR_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
        .update_clk   (update_clk),
        .reset_clk    (reset_clk),
        .ip           (ip),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .adj          (adj),
        .adj_strobe   (adj_strobe),
        .fault        (fault)
    );

    always #5 update_clk = ~update_clk;

    // Instruction pointer model: loadable, otherwise applies ip + adj on each strobe.
    always @(posedge update_clk) begin
        if (ip_load)         ip <= ip_load_val;
        else if (adj_strobe) ip <= ip + adj;
    end

    typedef struct packed {
        logic [15:0] ip0;
        logic [15:0] data;
        logic        taken;
        logic [15:0] off;
        logic [15:0] exp_adj;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge update_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] ip0);
        reset_clk     = 1'b1;
        mem_ack       = 1'b0;
        mem_data      = 16'h0000;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0000;
        ip_load       = 1'b1;
        ip_load_val   = ip0;
        tick();
        ip_load = 1'b0;
        tick();
        check("rst_ctl", {mem_req, instr_valid, adj_strobe, fault}, 4'b0000);
        check("rst_addr_instr", {mem_addr, instr}, 32'h0);
        check("rst_adj", adj, 16'h0);
        reset_clk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int strobes;
        reset_clk     = 1'b1;
        mem_ack       = 1'b0;
        mem_data      = 16'h0000;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0000;
        ip_load       = 1'b1;
        ip_load_val   = 16'h0000;

        vecs[0] = '{ip0: 16'h0010, data: 16'hA5A5, taken: 1'b0, off: 16'h1234, exp_adj: 16'h0001, exp_next: 16'h0011};
        vecs[1] = '{ip0: 16'h0008, data: 16'h1111, taken: 1'b1, off: 16'hFFFC, exp_adj: 16'hFFFC, exp_next: 16'h0004};
        vecs[2] = '{ip0: 16'hFFFF, data: 16'h2222, taken: 1'b0, off: 16'h0000, exp_adj: 16'h0001, exp_next: 16'h0000};
        vecs[3] = '{ip0: 16'h0040, data: 16'h3333, taken: 1'b1, off: 16'h0000, exp_adj: 16'h0000, exp_next: 16'h0040};
        vecs[4] = '{ip0: 16'h7FF0, data: 16'h4444, taken: 1'b1, off: 16'h0020, exp_adj: 16'h0020, exp_next: 16'h8010};

        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].ip0);
            tick();
            check("v_req", mem_req, 1'b1);
            check("v_addr", mem_addr, vecs[i].ip0);
            mem_ack  = 1'b1;
            mem_data = vecs[i].data;
            tick();
            mem_ack = 1'b0;
            check("v_valid", {instr_valid, mem_req}, 2'b10);
            check("v_instr", instr, vecs[i].data);
            instr_ready   = 1'b1;
            branch_taken  = vecs[i].taken;
            branch_offset = vecs[i].off;
            tick();
            instr_ready   = 1'b0;
            branch_taken  = 1'b1;
            branch_offset = 16'h5555;
            check("v_strobe", {adj_strobe, instr_valid}, 2'b10);
            check("v_adj", adj, vecs[i].exp_adj);
            tick();
            check("v_settle", {adj_strobe, mem_req}, 2'b00);
            check("v_adj_hold", adj, vecs[i].exp_adj);
            tick();
            check("v_next_req", mem_req, 1'b1);
            check("v_next_addr", mem_addr, vecs[i].exp_next);
        end

        // Decode stall: five cycles of ready low, with a stray ack and branch inputs.
        do_reset(16'h0100);
        tick();
        mem_ack  = 1'b1;
        mem_data = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("stall_enter", instr_valid, 1'b1);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mem_ack  = 1'b1;
                mem_data = 16'h0BAD;
            end
            branch_taken  = 1'b1;
            branch_offset = 16'h0F0F;
            tick();
            mem_ack = 1'b0;
            check("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, 16'hBEEF);
            if (adj_strobe) strobes++;
        end
        check("stall_no_strobe", strobes, 0);
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("stall_strobe", adj_strobe, 1'b1);
        check("stall_adj", adj, 16'h0001);
        tick();
        check("stall_strobe_once", adj_strobe, 1'b0);
        tick();
        check("stall_next_addr", {mem_req, mem_addr}, {1'b1, 16'h0101});

        // Asynchronous reset in mid-REQ; ack held through reset release is ignored.
        do_reset(16'h0200);
        tick();
        tick();
        check("async_pre", mem_req, 1'b1);
        #2;
        reset_clk = 1'b1;
        #1;
        check("async_req_drop", {mem_req, instr_valid}, 2'b00);
        ip_load     = 1'b1;
        ip_load_val = 16'h0300;
        mem_ack     = 1'b1;
        mem_data    = 16'hDEAD;
        tick();
        ip_load   = 1'b0;
        reset_clk = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("async_restart", {mem_req, mem_addr}, {1'b1, 16'h0300});
        check("async_stale_ack", {instr_valid, instr}, {1'b0, 16'h0000});
        tick();
        check("async_still_req", {mem_req, instr_valid}, 2'b10);

        // Back-to-back: ack and ready held high give one strobe every four cycles.
        do_reset(16'h0400);
        mem_ack     = 1'b1;
        mem_data    = 16'h7777;
        instr_ready = 1'b1;
        strobes     = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (adj_strobe) strobes++;
        end
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        check("b2b_strobes", strobes, 3);
        check("b2b_ip", ip, 16'h0403);

`ifdef FETCH_TIMEOUT_EN
        // No ack: fault after the fifteenth REQ cycle, then absorbing.
        do_reset(16'h0500);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("to_wait", {mem_req, fault}, 2'b10);
        tick();
        check("to_fault", {mem_req, fault}, 2'b01);
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        strobes     = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (adj_strobe || instr_valid) strobes++;
        end
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        check("to_absorb", strobes, 0);
        check("to_sticky", {mem_req, fault}, 2'b01);

        // Ack on exactly the fifteenth REQ cycle completes normally.
        do_reset(16'h0600);
        tick();
        for (int i = 0; i < 14; i++) tick();
        mem_ack  = 1'b1;
        mem_data = 16'hC0DE;
        tick();
        mem_ack = 1'b0;
        check("to_ack_last", {instr_valid, fault}, 2'b10);
        check("to_ack_instr", instr, 16'hC0DE);
`else
        // Without the timeout feature REQ waits indefinitely and fault stays low.
        do_reset(16'h0500);
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("no_to_wait", {mem_req, fault, instr_valid}, 3'b100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
